// File: rtl/writeback_arbiter.sv
// Register file write-side arbiter: ALU results take priority, load results
// wait in a small FIFO, and an anti-starvation counter stalls the ALU so that
// buffered loads still drain. A query port exposes pending load destinations.
module writeback_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Alu_Valid,
  output logic              Alu_Ready,
  input  logic [ADDR_W-1:0] Alu_Rd,
  input  logic [DATA_W-1:0] Alu_Data,
  input  logic              Ld_Valid,
  output logic              Ld_Ready,
  input  logic [ADDR_W-1:0] Ld_Rd,
  input  logic [DATA_W-1:0] Ld_Data,
  output logic              Write,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Query_Reg,
  output logic              Query_Hit
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned OCC_W = PTR_W + 1;

  // Load buffer storage and bookkeeping
  logic [ADDR_W-1:0] r_mem_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_ent_vld;
  logic [PTR_W-1:0]  r_wr_idx;
  logic [PTR_W-1:0]  r_rd_idx;
  logic [OCC_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_starve;

  logic              w_empty;
  logic              w_full;
  logic              w_alu_xfer;
  logic              w_ld_push;
  logic              w_pop;
  logic              w_sel_vld;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              w_query_hit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == OCC_W'(FIFO_DEPTH));
  assign Ld_Ready   = ~w_full;
  assign Alu_Ready  = (r_starve < CNT_W'(STARVE_LIMIT));
  assign w_alu_xfer = Alu_Valid & Alu_Ready;
  assign w_ld_push  = Ld_Valid & Ld_Ready;
  // Pop only from pre-edge occupancy, so a freshly pushed load waits a cycle
  assign w_pop      = ~w_alu_xfer & ~w_empty;
  assign Query_Hit  = w_query_hit;

  // Write-port source selection: ALU transfer, then FIFO head, else idle
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (w_alu_xfer) begin
      w_sel_vld  = 1'b1;
      w_sel_rd   = Alu_Rd;
      w_sel_data = Alu_Data;
    end else if (w_pop) begin
      w_sel_vld  = 1'b1;
      w_sel_rd   = r_mem_rd[r_rd_idx];
      w_sel_data = r_mem_data[r_rd_idx];
    end
  end

  // Starvation counter: counts ALU wins over a waiting load, cleared on pop or empty
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (w_alu_xfer && (r_starve != CNT_W'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + CNT_W'(1);
    end
  end

  // Pending-load lookup over live entries; x0 destinations never hit
  always_comb begin
    w_query_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_ent_vld[i] && (r_mem_rd[i] == Query_Reg) && (r_mem_rd[i] != '0)) begin
        w_query_hit = 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and entry-valid tracking
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_count   <= '0;
      r_ent_vld <= '0;
    end else begin
      if (w_ld_push) begin
        r_wr_idx <= r_wr_idx + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_idx <= r_rd_idx + PTR_W'(1);
      end
      case ({w_ld_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_ld_push && (r_wr_idx == PTR_W'(i))) begin
          r_ent_vld[i] <= 1'b1;
        end else if (w_pop && (r_rd_idx == PTR_W'(i))) begin
          r_ent_vld[i] <= 1'b0;
        end
      end
    end
  end

  // FIFO payload storage
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_rd[i]   <= '0;
        r_mem_data[i] <= '0;
      end
    end else if (w_ld_push) begin
      r_mem_rd[r_wr_idx]   <= Ld_Rd;
      r_mem_data[r_wr_idx] <= Ld_Data;
    end
  end

  // Starvation counter register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  // Registered write port; x0 results are consumed silently and address/data hold
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Write      <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
    end else begin
      Write <= w_sel_vld && (w_sel_rd != '0);
      if (w_sel_vld && (w_sel_rd != '0)) begin
        Write_Reg  <= w_sel_rd;
        Write_Data <= w_sel_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios followed by constrained-random
// traffic, all checked against a queue-based behavioural model.
module tb_writeback_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned LIM    = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Alu_Valid, Alu_Ready, Ld_Valid, Ld_Ready;
  logic [ADDR_W-1:0] Alu_Rd, Ld_Rd, Write_Reg, Query_Reg;
  logic [DATA_W-1:0] Alu_Data, Ld_Data, Write_Data;
  logic              Write, Query_Hit;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  ent_t              q[$];
  int                starve;
  logic              exp_w;
  logic [ADDR_W-1:0] exp_reg;
  logic [DATA_W-1:0] exp_data;
  bit                last_alu_acc, last_ld_acc;

  writeback_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Rd(Alu_Rd), .Alu_Data(Alu_Data),
    .Ld_Valid(Ld_Valid), .Ld_Ready(Ld_Ready), .Ld_Rd(Ld_Rd), .Ld_Data(Ld_Data),
    .Write(Write), .Write_Reg(Write_Reg), .Write_Data(Write_Data),
    .Query_Reg(Query_Reg), .Query_Hit(Query_Hit)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [ADDR_W-1:0] r);
    foreach (q[i]) if (q[i].rd == r && r != '0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    starve   = 0;
    exp_w    = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    last_alu_acc = 1'b0;
    last_ld_acc  = 1'b0;
  endtask

  // Apply one clock edge of the arbitration rules to the model
  task automatic model_step();
    bit   a_rdy     = (starve < LIM);
    bit   l_rdy     = (q.size() < DEPTH);
    bit   ax        = Alu_Valid && a_rdy;
    bit   lp        = Ld_Valid && l_rdy;
    bit   was_empty = (q.size() == 0);
    bit   sel       = 1'b0;
    bit   popped    = 1'b0;
    ent_t s         = '0;
    if (ax) begin
      s.rd = Alu_Rd; s.d = Alu_Data; sel = 1'b1;
    end else if (!was_empty) begin
      s = q.pop_front(); sel = 1'b1; popped = 1'b1;
    end
    exp_w = sel && (s.rd != '0);
    if (exp_w) begin
      exp_reg  = s.rd;
      exp_data = s.d;
    end
    if (was_empty || popped) starve = 0;
    else if (ax && starve < LIM) starve++;
    if (lp) q.push_back('{rd: Ld_Rd, d: Ld_Data});
    last_alu_acc = ax;
    last_ld_acc  = lp;
  endtask

  // Check every output against the model, then advance one clock
  task automatic cycle();
    #2;
    chk("alu_ready", 64'(Alu_Ready), 64'(starve < LIM));
    chk("ld_ready",  64'(Ld_Ready),  64'(q.size() < DEPTH));
    chk("query_hit", 64'(Query_Hit), 64'(model_hit(Query_Reg)));
    chk("write",     64'(Write),     64'(exp_w));
    chk("write_reg", 64'(Write_Reg), 64'(exp_reg));
    chk("write_data",64'(Write_Data),64'(exp_data));
    @(posedge Clock);
    model_step();
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    Alu_Valid = 1'b0; Alu_Rd = '0; Alu_Data = '0;
    Ld_Valid = 1'b0;  Ld_Rd = '0;  Ld_Data = '0;
    Query_Reg = '0;
    model_reset();

    // Reset state
    #2;
    chk("rst_write",     64'(Write), 64'(0));
    chk("rst_write_reg", 64'(Write_Reg), 64'(0));
    chk("rst_write_data",64'(Write_Data), 64'(0));
    chk("rst_ld_ready",  64'(Ld_Ready), 64'(1));
    chk("rst_alu_ready", 64'(Alu_Ready), 64'(1));
    chk("rst_query_hit", 64'(Query_Hit), 64'(0));
    @(posedge Clock); #1;
    Reset_n = 1'b1;

    // ALU only
    Alu_Valid = 1'b1; Alu_Rd = 5'd5; Alu_Data = 32'hDEADBEEF;
    cycle();
    Alu_Valid = 1'b0;
    chk("alu_write",     64'(Write), 64'(1));
    chk("alu_write_reg", 64'(Write_Reg), 64'(5));
    chk("alu_write_data",64'(Write_Data), 64'hDEADBEEF);
    chk("alu_ready_hold",64'(Alu_Ready), 64'(1));
    cycle();

    // Load into empty FIFO, two-cycle latency
    Ld_Valid = 1'b1; Ld_Rd = 5'd7; Ld_Data = 32'h1234; Query_Reg = 5'd7;
    cycle();
    Ld_Valid = 1'b0;
    #1 chk("ld_hit_n1", 64'(Query_Hit), 64'(1));
    chk("ld_nowrite_n1", 64'(Write), 64'(0));
    cycle();
    chk("ld_write_n2", 64'(Write), 64'(1));
    chk("ld_reg_n2",   64'(Write_Reg), 64'(7));
    chk("ld_hit_gone", 64'(Query_Hit), 64'(0));
    cycle();

    // Collision: ALU first, load one cycle later
    Alu_Valid = 1'b1; Alu_Rd = 5'd3; Alu_Data = 32'h33;
    Ld_Valid  = 1'b1; Ld_Rd  = 5'd4; Ld_Data  = 32'h44;
    cycle();
    Alu_Valid = 1'b0; Ld_Valid = 1'b0;
    chk("col_first", 64'(Write_Reg), 64'(3));
    cycle();
    chk("col_second", 64'(Write_Reg), 64'(4));
    chk("col_second_w", 64'(Write), 64'(1));
    cycle();

    // Fill FIFO to two entries, third load back-pressured until a pop
    Alu_Valid = 1'b1; Alu_Rd = 5'd10; Alu_Data = 32'hA0;
    Ld_Valid  = 1'b1; Ld_Rd  = 5'd11; Ld_Data  = 32'hB1;
    cycle();
    Alu_Rd = 5'd14; Alu_Data = 32'hA4;
    Ld_Rd  = 5'd12; Ld_Data  = 32'hB2;
    cycle();
    Ld_Rd = 5'd13; Ld_Data = 32'hB3;
    chk("full_ld_ready0", 64'(Ld_Ready), 64'(0));
    cycle();
    chk("full_ld_ready1", 64'(Ld_Ready), 64'(0));
    Alu_Valid = 1'b0;
    cycle();
    chk("full_pop_ready", 64'(Ld_Ready), 64'(1));
    chk("full_pop_reg",   64'(Write_Reg), 64'(11));
    cycle();
    Ld_Valid = 1'b0;
    repeat (3) cycle();

    // Starvation: four ALU wins, one forced load write, ALU resumes
    Alu_Valid = 1'b1; Alu_Rd = 5'd20; Alu_Data = 32'h20;
    Ld_Valid  = 1'b1; Ld_Rd  = 5'd9;  Ld_Data  = 32'h99;
    Query_Reg = 5'd9;
    cycle();
    Ld_Valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      Alu_Rd = ADDR_W'(21 + k); Alu_Data = DATA_W'(32'h100 + k);
      chk("starve_alu_rdy", 64'(Alu_Ready), 64'(1));
      cycle();
      chk("starve_alu_wr", 64'(Write_Reg), 64'(21 + k));
    end
    chk("starve_stall", 64'(Alu_Ready), 64'(0));
    cycle();
    chk("starve_ld_reg",  64'(Write_Reg), 64'(9));
    chk("starve_ld_data", 64'(Write_Data), 64'h99);
    chk("starve_resume",  64'(Alu_Ready), 64'(1));
    Alu_Valid = 1'b0;
    cycle();

    // x0 drop on both paths
    Alu_Valid = 1'b1; Alu_Rd = 5'd0; Alu_Data = 32'hFFFFFFFF;
    chk("x0_alu_ready", 64'(Alu_Ready), 64'(1));
    cycle();
    Alu_Valid = 1'b0;
    chk("x0_alu_nowrite", 64'(Write), 64'(0));
    chk("x0_alu_hold",    64'(Write_Data), 64'h99);
    Ld_Valid = 1'b1; Ld_Rd = 5'd0; Ld_Data = 32'h55; Query_Reg = 5'd0;
    cycle();
    Ld_Valid = 1'b0;
    chk("x0_ld_nohit", 64'(Query_Hit), 64'(0));
    cycle();
    chk("x0_ld_nowrite", 64'(Write), 64'(0));
    chk("x0_ld_hold",    64'(Write_Reg), 64'(9));
    cycle();

    // Asynchronous reset with a full FIFO
    Alu_Valid = 1'b1; Alu_Rd = 5'd1; Alu_Data = 32'h11;
    Ld_Valid  = 1'b1; Ld_Rd  = 5'd2; Ld_Data  = 32'h22;
    cycle();
    Alu_Rd = 5'd4; Alu_Data = 32'h44;
    Ld_Rd  = 5'd3; Ld_Data  = 32'h33;
    cycle();
    Ld_Valid = 1'b0; Query_Reg = 5'd2;
    #1 chk("pre_rst_hit", 64'(Query_Hit), 64'(1));
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_write",  64'(Write), 64'(0));
    chk("mid_rst_reg",    64'(Write_Reg), 64'(0));
    chk("mid_rst_ldrdy",  64'(Ld_Ready), 64'(1));
    chk("mid_rst_alurdy", 64'(Alu_Ready), 64'(1));
    chk("mid_rst_hit",    64'(Query_Hit), 64'(0));
    model_reset();
    Alu_Valid = 1'b0;
    #1 Reset_n = 1'b1;
    repeat (4) cycle();

    // Random traffic; payloads held while a valid is stalled
    for (int n = 0; n < 400; n++) begin
      if (!Alu_Valid || last_alu_acc) begin
        Alu_Valid = ($urandom_range(0, 99) < 60);
        Alu_Rd    = ADDR_W'($urandom_range(0, 7));
        Alu_Data  = DATA_W'($urandom);
      end
      if (!Ld_Valid || last_ld_acc) begin
        Ld_Valid = ($urandom_range(0, 99) < 50);
        Ld_Rd    = ADDR_W'($urandom_range(0, 7));
        Ld_Data  = DATA_W'($urandom);
      end
      Query_Reg = ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    Alu_Valid = 1'b0; Ld_Valid = 1'b0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
